// File: rtl/rtc_alarm_core.sv
`default_nettype none
// ============================================================================
// Module   : rtc_alarm_core
// Brief    : Prescaled BCD HH:MM:SS real-time clock with 12/24 h display,
//            field-wise time/alarm setting and an alarm ring/snooze FSM.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_alarm_core #(
    parameter int TICK_DIV   = 100000000,
    parameter int TICK_BITS  = 27,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic       run,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       alarm_sel,
    input  logic       inc,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       mode_12h,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       pm,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse,
    output logic       ringing
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RINGING = 2'd2;
    localparam logic [1:0] ST_SNOOZE  = 2'd3;

    localparam logic [TICK_BITS-1:0] c_tick_last   = TICK_BITS'(TICK_DIV - 1);
    localparam logic [7:0]           c_ring_last   = 8'(RING_SECS - 1);
    localparam logic [5:0]           c_snooze_load = 6'(SNOOZE_MIN);

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic [TICK_BITS-1:0] r_presc;
    logic [7:0]           r_sec;
    logic [7:0]           r_min;
    logic [7:0]           r_hour;
    logic [7:0]           r_al_min;
    logic [7:0]           r_al_hour;
    logic [1:0]           r_state;
    logic [7:0]           r_ring_cnt;
    logic [5:0]           r_snz_cnt;
    logic                 r_sec_pulse;
    logic                 r_min_pulse;
    logic                 r_hour_pulse;
    logic                 r_day_pulse;

    logic       w_tick;
    logic       w_min_carry;
    logic       w_hour_carry;
    logic       w_day_carry;
    logic [7:0] w_sec_next;
    logic [7:0] w_min_next;
    logic [7:0] w_hour_next;
    logic [7:0] w_new_sec;
    logic [7:0] w_new_min;
    logic [7:0] w_new_hour;
    logic       w_alarm_hit;
    logic       w_edit_time;
    logic       w_edit_alarm;

    assign w_tick       = run && !set_en && (r_presc == c_tick_last);
    assign w_min_carry  = w_tick && (r_sec == 8'h59);
    assign w_hour_carry = w_min_carry && (r_min == 8'h59);
    assign w_day_carry  = w_hour_carry && (r_hour == 8'h23);

    assign w_sec_next  = bcd_inc(r_sec, 8'h59);
    assign w_min_next  = bcd_inc(r_min, 8'h59);
    assign w_hour_next = bcd_inc(r_hour, 8'h23);

    assign w_new_sec  = w_tick       ? w_sec_next  : r_sec;
    assign w_new_min  = w_min_carry  ? w_min_next  : r_min;
    assign w_new_hour = w_hour_carry ? w_hour_next : r_hour;

    // Match is evaluated against the time being written on this tick edge.
    assign w_alarm_hit = w_tick && (w_new_sec == 8'h00) &&
                         (w_new_min == r_al_min) && (w_new_hour == r_al_hour);

    assign w_edit_time  = set_en && inc && !alarm_sel;
    assign w_edit_alarm = set_en && inc && alarm_sel;

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            r_presc <= '0;
        end else if (set_en) begin
            r_presc <= '0;
        end else if (run) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            r_sec  <= 8'h00;
            r_min  <= 8'h00;
            r_hour <= 8'h00;
        end else if (w_tick) begin
            r_sec  <= w_new_sec;
            r_min  <= w_new_min;
            r_hour <= w_new_hour;
        end else if (w_edit_time) begin
            case (set_sel)
                2'd0:    r_sec  <= 8'h00;
                2'd1:    r_min  <= w_min_next;
                2'd2:    r_hour <= w_hour_next;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            r_al_min  <= 8'h00;
            r_al_hour <= 8'h00;
        end else if (w_edit_alarm) begin
            case (set_sel)
                2'd1:    r_al_min  <= bcd_inc(r_al_min, 8'h59);
                2'd2:    r_al_hour <= bcd_inc(r_al_hour, 8'h23);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            r_sec_pulse  <= 1'b0;
            r_min_pulse  <= 1'b0;
            r_hour_pulse <= 1'b0;
            r_day_pulse  <= 1'b0;
        end else begin
            r_sec_pulse  <= w_tick;
            r_min_pulse  <= w_min_carry;
            r_hour_pulse <= w_hour_carry;
            r_day_pulse  <= w_day_carry;
        end
    end

    // Counters only advance on ticks, so frozen time also freezes them.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            r_state    <= ST_IDLE;
            r_ring_cnt <= 8'd0;
            r_snz_cnt  <= 6'd0;
        end else if (!alarm_en) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_alarm_hit) begin
                        r_state    <= ST_RINGING;
                        r_ring_cnt <= 8'd0;
                    end
                end
                ST_RINGING: begin
                    if (snooze) begin
                        r_state   <= ST_SNOOZE;
                        r_snz_cnt <= c_snooze_load;
                    end else if (w_tick) begin
                        if (r_ring_cnt == c_ring_last)
                            r_state <= ST_ARMED;
                        else
                            r_ring_cnt <= r_ring_cnt + 8'd1;
                    end
                end
                ST_SNOOZE: begin
                    if (w_min_carry) begin
                        if (r_snz_cnt <= 6'd1) begin
                            r_state    <= ST_RINGING;
                            r_ring_cnt <= 8'd0;
                            r_snz_cnt  <= 6'd0;
                        end else begin
                            r_snz_cnt <= r_snz_cnt - 6'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    logic       w_show_alarm;
    logic [7:0] w_disp_hour;
    logic [4:0] w_h_bin;
    logic [4:0] w_h12;
    logic [7:0] w_hh;
    logic       w_pm;

    assign w_show_alarm = set_en && alarm_sel;
    assign w_disp_hour  = w_show_alarm ? r_al_hour : r_hour;
    assign w_h_bin      = 5'(w_disp_hour[7:4]) * 5'd10 + 5'(w_disp_hour[3:0]);

    always_comb begin
        w_h12 = w_h_bin;
        w_hh  = w_disp_hour;
        w_pm  = 1'b0;
        if (mode_12h) begin
            w_pm = (w_h_bin >= 5'd12);
            if (w_h_bin == 5'd0)
                w_h12 = 5'd12;
            else if (w_h_bin > 5'd12)
                w_h12 = w_h_bin - 5'd12;
            if (w_h12 >= 5'd10)
                w_hh = {4'd1, 4'(w_h12 - 5'd10)};
            else
                w_hh = {4'd0, w_h12[3:0]};
        end
    end

    assign hh_bcd     = w_hh;
    assign mm_bcd     = w_show_alarm ? r_al_min : r_min;
    assign ss_bcd     = w_show_alarm ? 8'h00 : r_sec;
    assign pm         = w_pm;
    assign sec_pulse  = r_sec_pulse;
    assign min_pulse  = r_min_pulse;
    assign hour_pulse = r_hour_pulse;
    assign day_pulse  = r_day_pulse;
    assign ringing    = (r_state == ST_RINGING);

endmodule
`default_nettype wire
